// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - multi-channel push-button debouncer with press/release pulses and auto-repeat
// The release and event outputs are named rel and evt because release and event are SystemVerilog keywords.
module btn_conditioner #(
  parameter int                NUM_CH       = 4,
  parameter int                SAMPLES      = 3,
  parameter logic [NUM_CH-1:0] REPEAT_MASK  = {NUM_CH{1'b0}},
  parameter int                REPEAT_DELAY = 8,
  parameter int                REPEAT_RATE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [NUM_CH-1:0] btn,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] rel,
  output logic [NUM_CH-1:0] evt
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Only SAMPLES-1 past samples are kept; the live btn bit completes the window.
    logic [SAMPLES-2:0] hist;
    logic [SAMPLES-1:0] win;
    logic               lvl_q, press_q, rel_q, evt_q;
    logic               rise, fall;
    rpt_state_t         state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic               rpt_fire;

    assign win  = {hist, btn[i]};
    assign rise = tick && (&win) && !lvl_q;
    assign fall = tick && !(|win) && lvl_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hist    <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        evt_q   <= 1'b0;
        state   <= IDLE;
        cnt     <= '0;
      end else begin
        if (tick) hist <= win[SAMPLES-2:0];
        if (rise)      lvl_q <= 1'b1;
        else if (fall) lvl_q <= 1'b0;
        press_q <= rise;
        rel_q   <= fall;
        evt_q   <= rise | rpt_fire;
        state   <= state_nx;
        cnt     <= cnt_nx;
      end
    end

    // A release on the expiry tick takes priority, so no repeat is emitted.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rpt_fire = 1'b0;
      case (state)
        IDLE: begin
          if (rise && REPEAT_MASK[i]) begin
            state_nx = DELAY;
            cnt_nx   = CW'(REPEAT_DELAY);
          end
        end
        DELAY, RPT: begin
          if (fall) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (tick) begin
            if (cnt == CW'(1)) begin
              rpt_fire = 1'b1;
              state_nx = RPT;
              cnt_nx   = CW'(REPEAT_RATE);
            end else begin
              cnt_nx = cnt - CW'(1);
            end
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    assign level[i] = lvl_q;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
    assign evt[i]   = evt_q;
  end

endmodule
